// File: rtl/ddr_deser.sv
// ddr_deser: word aligner and FWFT FIFO behind a 2-bit-per-clock DDR capture stage.
//   clk       clock shared with the DDR capture stage
//   rst       synchronous reset, active-high
//   din       captured pair; din[0] is the older bit, din[1] the newer bit
//   resync    one-cycle pulse: drop lock, flush the FIFO, clear overflow
//   data_o    FIFO head word, meaningful while valid=1
//   valid     FIFO non-empty
//   ready     consumer accepts the head word when valid & ready
//   locked    high while word alignment is locked
//   overflow  sticky: a word was dropped because the FIFO was full
// The bit stream is hunted for SYNC at either bit alignment. Once locked, each
// aligned non-SYNC word is pushed into the FIFO; SYNC words are idle fill.
module ddr_deser #(
  parameter int unsigned    w     = 8,
  parameter logic [w-1:0]   SYNC  = w'(8'hA5),
  parameter int unsigned    depth = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   din,
  input  logic         resync,
  output logic [w-1:0] data_o,
  output logic         valid,
  input  logic         ready,
  output logic         locked,
  output logic         overflow
);

  localparam int unsigned     CntW    = (w > 4) ? $clog2(w / 2) : 1;
  localparam int unsigned     AW      = $clog2(depth);
  localparam logic [CntW-1:0] CntLast = CntW'(w / 2 - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [AW:0]     PtrOne  = (AW + 1)'(1);

  typedef enum logic {StHunt, StLocked} state_e;

  state_e          state_q, state_d;
  logic [w:0]      sr_q;
  logic            phase_q, phase_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [AW:0]     wr_q, rd_q;
  logic [w-1:0]    mem_q [depth];
  logic            overflow_q;

  logic [w-1:0] win_a, win_b, word;
  logic         push, pop, full, push_ok, push_drop;

  // Window A ends on the newest bit, window B one bit earlier.
  assign win_a = sr_q[w-1:0];
  assign win_b = sr_q[w:1];
  assign word  = phase_q ? win_b : win_a;

  // The lock cycle already holds the first pair after SYNC, so a word is
  // complete in the window when cnt reaches its last value.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    if (resync) begin
      state_d = StHunt;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StHunt: begin
          if (win_a == SYNC) begin
            state_d = StLocked;
            phase_d = 1'b0;
            cnt_d   = '0;
          end else if (win_b == SYNC) begin
            state_d = StLocked;
            phase_d = 1'b1;
            cnt_d   = '0;
          end
        end
        StLocked: begin
          cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + CntOne;
          push  = (cnt_q == CntLast) && (word != SYNC);
        end
        default: state_d = StHunt;
      endcase
    end
  end

  // Pointers carry one extra wrap bit; full when only the wrap bits differ.
  assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign valid     = (wr_q != rd_q);
  assign pop       = valid & ready & ~resync;
  assign push_ok   = push & (~full | pop);
  assign push_drop = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q       <= '0;
      state_q    <= StHunt;
      phase_q    <= 1'b0;
      cnt_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      overflow_q <= 1'b0;
      mem_q      <= '{default: '0};
    end else begin
      sr_q    <= {sr_q[w-2:0], din[0], din[1]};
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      if (resync) begin
        // Flush by moving the write pointer so the stale head stays put.
        wr_q       <= rd_q;
        overflow_q <= 1'b0;
      end else begin
        if (push_ok) begin
          mem_q[wr_q[AW-1:0]] <= word;
          wr_q                <= wr_q + PtrOne;
        end
        if (pop) rd_q <= rd_q + PtrOne;
        if (push_drop) overflow_q <= 1'b1;
      end
    end
  end

  assign data_o   = mem_q[rd_q[AW-1:0]];
  assign locked   = (state_q == StLocked);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ddr_deser.sv
// Bench for ddr_deser (w=8, SYNC=A5, depth=16). A bit-stream model finds the
// SYNC word, slices the following bits into words and keeps a FIFO queue.
module tb_ddr_deser;

  localparam int         W     = 8;
  localparam logic [7:0] SYNCW = 8'hA5;
  localparam int         DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       resync = 1'b0;
  logic       ready = 1'b0;
  logic [1:0] din = 2'b00;
  logic [7:0] data_o;
  logic       valid, locked, overflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ddr_deser #(.w(W), .SYNC(SYNCW), .depth(DEPTH)) dut (
    .clk(clk), .rst(rst), .din(din), .resync(resync), .data_o(data_o),
    .valid(valid), .ready(ready), .locked(locked), .overflow(overflow)
  );

  // Model state: captured bits, hunting flag, bits past the last word
  // boundary, FIFO contents and sticky overflow.
  bit         hist[$];
  bit         m_hunt;
  int         m_pend;
  logic [7:0] m_fifo[$];
  bit         m_ovf;

  bit         stream[$];
  logic [7:0] popped[$];
  logic [7:0] ws[$];

  function automatic logic [7:0] hist_word(input int start);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = hist[start+i];
    return r;
  endfunction

  task automatic model_edge(input bit b0, input bit b1, input bit do_rst, input bit do_rs,
                            input bit rdy);
    int n;
    bit mpop, mpush;
    logic [7:0] wd;
    if (do_rst) begin
      hist.delete();
      repeat (W + 1) hist.push_back(1'b0);
      m_hunt = 1'b1;
      m_pend = 0;
      m_fifo.delete();
      m_ovf = 1'b0;
      return;
    end
    n = hist.size();
    mpop = (m_fifo.size() > 0) && rdy && !do_rs;
    mpush = 1'b0;
    wd = '0;
    if (do_rs) begin
      m_hunt = 1'b1;
      m_fifo.delete();
      m_ovf = 1'b0;
      mpop = 1'b0;
    end else if (m_hunt) begin
      if (hist_word(n - W) == SYNCW) begin
        m_hunt = 1'b0;
        m_pend = 0;
      end else if (hist_word(n - W - 1) == SYNCW) begin
        m_hunt = 1'b0;
        m_pend = 1;
      end
    end else if (m_pend >= W) begin
      wd = hist_word(n - m_pend);
      m_pend -= W;
      mpush = (wd != SYNCW);
    end
    if (mpop) void'(m_fifo.pop_front());
    if (mpush) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back(wd);
      else m_ovf = 1'b1;
    end
    hist.push_back(b0);
    hist.push_back(b1);
    if (!m_hunt) m_pend += 2;
    while (hist.size() > 32) hist.delete(0);
  endtask

  // One clock: drive, record a DUT pop at the negedge, advance the model at
  // the posedge, return 1 time unit later for sampling.
  task automatic cycle(input bit b0, input bit b1, input bit do_rst, input bit do_rs);
    din = {b1, b0};
    rst = do_rst;
    resync = do_rs;
    @(negedge clk);
    if (valid && ready && !do_rst && !do_rs) popped.push_back(data_o);
    @(posedge clk);
    model_edge(b0, b1, do_rst, do_rs, ready);
    #1;
    rst = 1'b0;
    resync = 1'b0;
  endtask

  task automatic push_word(input logic [7:0] wd);
    for (int i = 7; i >= 0; i--) stream.push_back(wd[i]);
  endtask

  task automatic gen_words(input int n);
    logic [7:0] wd;
    bit dup;
    ws.delete();
    for (int i = 0; i < n; i++) begin
      do begin
        wd = 8'($urandom);
        dup = 1'b0;
        foreach (ws[j]) if (ws[j] == wd) dup = 1'b1;
      end while (dup || wd == SYNCW);
      ws.push_back(wd);
    end
  endtask

  task automatic test_reset();
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    checks += 4;
    if (valid !== 1'b0) begin errors++; $display("FAIL reset valid: got %b want 0", valid); end
    if (locked !== 1'b0) begin errors++; $display("FAIL reset locked: got %b want 0", locked); end
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL reset overflow: got %b want 0", overflow);
    end
    if (data_o !== 8'h00) begin errors++; $display("FAIL reset data_o: got %h want 00", data_o); end
  endtask

  task automatic test_phase0();
    bit b0, b1;
    int k;
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    popped.delete();
    ready = 1'b1;
    push_word(8'hA5); push_word(8'h3C); push_word(8'h81); push_word(8'hA5); push_word(8'hA5);
    k = 0;
    while (stream.size() >= 2) begin
      b0 = stream.pop_front();
      b1 = stream.pop_front();
      cycle(b0, b1, 1'b0, 1'b0);
      k++;
      checks += 3;
      if (valid !== (m_fifo.size() != 0)) begin
        errors++; $display("FAIL phase0 valid k=%0d: got %b want %b", k, valid, m_fifo.size() != 0);
      end
      if (locked !== !m_hunt) begin
        errors++; $display("FAIL phase0 locked k=%0d: got %b want %b", k, locked, !m_hunt);
      end
      if (overflow !== m_ovf) begin
        errors++; $display("FAIL phase0 overflow k=%0d: got %b want %b", k, overflow, m_ovf);
      end
      if (m_fifo.size() != 0) begin
        checks++;
        if (data_o !== m_fifo[0]) begin
          errors++; $display("FAIL phase0 data_o k=%0d: got %h want %h", k, data_o, m_fifo[0]);
        end
      end
      if (k == 5) begin
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL phase0 lock: got %b want 1", locked); end
      end
      if (k == 9 || k == 13) begin
        checks++;
        if (valid !== 1'b1 || data_o !== ((k == 9) ? 8'h3C : 8'h81)) begin
          errors++;
          $display("FAIL phase0 latency k=%0d: got valid=%b data_o=%h want valid=1 data_o=%h",
                   k, valid, data_o, (k == 9) ? 8'h3C : 8'h81);
        end
      end
    end
    checks++;
    if (popped.size() != 2 || popped[0] !== 8'h3C || popped[1] !== 8'h81) begin
      errors++; $display("FAIL phase0 words: got %p want 3c 81", popped);
    end
  endtask

  task automatic test_phase1();
    bit b0, b1;
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    popped.delete();
    ready = 1'b1;
    stream.push_back(1'b1);
    push_word(8'hA5); push_word(8'h3C); push_word(8'hA5);
    stream.push_back(1'b0);
    while (stream.size() >= 2) begin
      b0 = stream.pop_front();
      b1 = stream.pop_front();
      cycle(b0, b1, 1'b0, 1'b0);
      checks += 3;
      if (valid !== (m_fifo.size() != 0)) begin
        errors++; $display("FAIL phase1 valid: got %b want %b", valid, m_fifo.size() != 0);
      end
      if (locked !== !m_hunt) begin
        errors++; $display("FAIL phase1 locked: got %b want %b", locked, !m_hunt);
      end
      if (overflow !== m_ovf) begin
        errors++; $display("FAIL phase1 overflow: got %b want %b", overflow, m_ovf);
      end
      if (m_fifo.size() != 0) begin
        checks++;
        if (data_o !== m_fifo[0]) begin
          errors++; $display("FAIL phase1 data_o: got %h want %h", data_o, m_fifo[0]);
        end
      end
    end
    checks += 2;
    if (locked !== 1'b1) begin errors++; $display("FAIL phase1 lock: got %b want 1", locked); end
    if (popped.size() != 1 || popped[0] !== 8'h3C) begin
      errors++; $display("FAIL phase1 words: got %p want 3c", popped);
    end
  endtask

  task automatic test_idle();
    bit b0, b1;
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    popped.delete();
    ready = 1'b1;
    push_word(8'hA5); push_word(8'h11); push_word(8'hA5); push_word(8'hA5);
    push_word(8'h22); push_word(8'hA5); push_word(8'hA5);
    while (stream.size() >= 2) begin
      b0 = stream.pop_front();
      b1 = stream.pop_front();
      cycle(b0, b1, 1'b0, 1'b0);
      checks += 3;
      if (valid !== (m_fifo.size() != 0)) begin
        errors++; $display("FAIL idle valid: got %b want %b", valid, m_fifo.size() != 0);
      end
      if (locked !== !m_hunt) begin
        errors++; $display("FAIL idle locked: got %b want %b", locked, !m_hunt);
      end
      if (overflow !== m_ovf) begin
        errors++; $display("FAIL idle overflow: got %b want %b", overflow, m_ovf);
      end
      if (m_fifo.size() != 0) begin
        checks++;
        if (data_o !== m_fifo[0]) begin
          errors++; $display("FAIL idle data_o: got %h want %h", data_o, m_fifo[0]);
        end
      end
    end
    checks++;
    if (popped.size() != 2 || popped[0] !== 8'h11 || popped[1] !== 8'h22) begin
      errors++; $display("FAIL idle words: got %p want 11 22", popped);
    end
  endtask

  // Fill with ready low; with pop_at >= 0, raise ready for exactly one cycle at
  // that pair index so a pop coincides with a push into the full FIFO.
  task automatic fill_run(input string nm, input int pop_at);
    bit b0, b1;
    int k;
    k = 0;
    while (stream.size() >= 2) begin
      b0 = stream.pop_front();
      b1 = stream.pop_front();
      ready = (k == pop_at);
      cycle(b0, b1, 1'b0, 1'b0);
      k++;
    end
    ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit b0, b1;
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    popped.delete();
    gen_words(17);
    push_word(8'hA5);
    foreach (ws[i]) push_word(ws[i]);
    push_word(8'hA5); push_word(8'hA5);
    fill_run("backpressure", -1);
    checks += 3;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL backpressure overflow: got %b want 1", overflow);
    end
    if (valid !== 1'b1) begin errors++; $display("FAIL backpressure valid: got %b want 1", valid); end
    if (data_o !== ws[0]) begin
      errors++; $display("FAIL backpressure head: got %h want %h", data_o, ws[0]);
    end
    ready = 1'b1;
    repeat (5) push_word(8'hA5);
    while (stream.size() >= 2) begin
      b0 = stream.pop_front();
      b1 = stream.pop_front();
      cycle(b0, b1, 1'b0, 1'b0);
      checks += 2;
      if (valid !== (m_fifo.size() != 0)) begin
        errors++; $display("FAIL backpressure drain valid: got %b want %b", valid, m_fifo.size() != 0);
      end
      if (overflow !== m_ovf) begin
        errors++; $display("FAIL backpressure drain overflow: got %b want %b", overflow, m_ovf);
      end
      if (m_fifo.size() != 0) begin
        checks++;
        if (data_o !== m_fifo[0]) begin
          errors++; $display("FAIL backpressure drain data_o: got %h want %h", data_o, m_fifo[0]);
        end
      end
    end
    checks += 2;
    if (popped.size() != 16) begin
      errors++; $display("FAIL backpressure count: got %0d want 16", popped.size());
    end
    for (int i = 0; i < 16 && i < popped.size(); i++) begin
      if (popped[i] !== ws[i]) begin
        errors++; $display("FAIL backpressure order %0d: got %h want %h", i, popped[i], ws[i]);
      end
    end
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL backpressure sticky: got %b want 1", overflow);
    end
  endtask

  task automatic test_full_pop();
    bit b0, b1;
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    popped.delete();
    gen_words(17);
    push_word(8'hA5);
    foreach (ws[i]) push_word(ws[i]);
    push_word(8'hA5);
    // 17th word's push edge is the cycle of the first pair after it.
    fill_run("full_pop", 4 + 17 * 4);
    checks += 3;
    if (overflow !== 1'b0) begin errors++; $display("FAIL full_pop overflow: got %b want 0", overflow); end
    if (m_fifo.size() != DEPTH || valid !== 1'b1) begin
      errors++; $display("FAIL full_pop level: got valid=%b model=%0d want 16", valid, m_fifo.size());
    end
    if (popped.size() != 1 || data_o !== ws[1]) begin
      errors++; $display("FAIL full_pop head: got %h pops=%0d want %h pops=1", data_o, popped.size(), ws[1]);
    end
    ready = 1'b1;
    repeat (5) push_word(8'hA5);
    while (stream.size() >= 2) begin
      b0 = stream.pop_front();
      b1 = stream.pop_front();
      cycle(b0, b1, 1'b0, 1'b0);
      checks += 2;
      if (valid !== (m_fifo.size() != 0)) begin
        errors++; $display("FAIL full_pop valid: got %b want %b", valid, m_fifo.size() != 0);
      end
      if (overflow !== m_ovf) begin
        errors++; $display("FAIL full_pop drain overflow: got %b want %b", overflow, m_ovf);
      end
    end
    checks++;
    if (popped.size() != 17 || popped[16] !== ws[16] || popped[0] !== ws[0]) begin
      errors++; $display("FAIL full_pop words: got %p want %p", popped, ws);
    end
  endtask

  task automatic test_resync();
    bit b0, b1;
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    popped.delete();
    ready = 1'b0;
    push_word(8'hA5); push_word(8'h12); push_word(8'h34); push_word(8'h56);
    push_word(8'h78); push_word(8'h9A); push_word(8'hA5);
    fill_run("resync", -1);
    checks++;
    if (m_fifo.size() != 5 || valid !== 1'b1) begin
      errors++; $display("FAIL resync queued: got valid=%b model=%0d want 5", valid, m_fifo.size());
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    checks += 3;
    if (valid !== 1'b0) begin errors++; $display("FAIL resync valid: got %b want 0", valid); end
    if (locked !== 1'b0) begin errors++; $display("FAIL resync locked: got %b want 0", locked); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL resync overflow: got %b want 0", overflow); end
    ready = 1'b1;
    push_word(8'h00); push_word(8'hA5); push_word(8'h42); push_word(8'hA5);
    while (stream.size() >= 2) begin
      b0 = stream.pop_front();
      b1 = stream.pop_front();
      cycle(b0, b1, 1'b0, 1'b0);
      checks += 3;
      if (valid !== (m_fifo.size() != 0)) begin
        errors++; $display("FAIL resync relock valid: got %b want %b", valid, m_fifo.size() != 0);
      end
      if (locked !== !m_hunt) begin
        errors++; $display("FAIL resync relock locked: got %b want %b", locked, !m_hunt);
      end
      if (m_fifo.size() != 0) begin
        if (data_o !== m_fifo[0]) begin
          errors++; $display("FAIL resync relock data_o: got %h want %h", data_o, m_fifo[0]);
        end
      end else if (overflow !== m_ovf) begin
        errors++; $display("FAIL resync relock overflow: got %b want %b", overflow, m_ovf);
      end
    end
    checks++;
    if (popped.size() != 1 || popped[0] !== 8'h42) begin
      errors++; $display("FAIL resync words: got %p want 42", popped);
    end
    push_word(8'h33); push_word(8'hA5);
    fill_run("resync", -1);
    checks++;
    if (valid !== 1'b1 || locked !== 1'b1) begin
      errors++; $display("FAIL resync prefill: got valid=%b locked=%b want 1 1", valid, locked);
    end
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({valid, locked, overflow, data_o} !== 11'd0) begin
      errors++;
      $display("FAIL rst while locked: got valid=%b locked=%b overflow=%b data_o=%h want all 0",
               valid, locked, overflow, data_o);
    end
  endtask

  task automatic test_random();
    bit b0, b1;
    int idx;
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    push_word(8'hA5);
    repeat (40) push_word(($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom));
    idx = 0;
    while (stream.size() >= 2) begin
      b0 = stream.pop_front();
      b1 = stream.pop_front();
      ready = 1'($urandom_range(0, 1));
      cycle(b0, b1, 1'b0, idx == 70);
      idx++;
      checks += 3;
      if (valid !== (m_fifo.size() != 0)) begin
        errors++; $display("FAIL random valid i=%0d: got %b want %b", idx, valid, m_fifo.size() != 0);
      end
      if (locked !== !m_hunt) begin
        errors++; $display("FAIL random locked i=%0d: got %b want %b", idx, locked, !m_hunt);
      end
      if (overflow !== m_ovf) begin
        errors++; $display("FAIL random overflow i=%0d: got %b want %b", idx, overflow, m_ovf);
      end
      if (m_fifo.size() != 0) begin
        checks++;
        if (data_o !== m_fifo[0]) begin
          errors++; $display("FAIL random data_o i=%0d: got %h want %h", idx, data_o, m_fifo[0]);
        end
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_phase0();
    test_phase1();
    test_idle();
    test_backpressure();
    test_full_pop();
    test_resync();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
